// File: rtl/trigger_delay_pkg.sv
// Shared trigger-delay types: edge-mode encodings, pulse-generator state enum and helpers.
`ifndef TRIGGER_DELAY_DEFS_VH
`define TRIGGER_DELAY_DEFS_VH
`define EDGE_NONE    2'd0
`define EDGE_RISING  2'd1
`define EDGE_FALLING 2'd2
`define EDGE_BOTH    2'd3
`endif

package trigger_delay_pkg;

  typedef enum logic [1:0] {PG_IDLE, PG_ACTIVE, PG_GAP} pgen_state_t;

  localparam int PG_MIN_LEN = 1;

  // Resting pin level for a mode; BOTH keeps whatever level the pin already has.
  function automatic logic idle_level(input logic [1:0] mode, input logic cur);
    logic lvl;
    lvl = 1'b0;
    case (mode)
      `EDGE_FALLING: lvl = 1'b1;
      `EDGE_BOTH:    lvl = cur;
      default:       lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/edge_pulse_gen.sv
// Turns a one-cycle fire strobe into a registered trigger edge/pulse on the output pin.
// Optional multi-pulse trains are built when PULSE_TRAIN_EN is defined.
module edge_pulse_gen
  import trigger_delay_pkg::*;
#(
  parameter int WIDTH_BITS = 16,
  parameter int COUNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fire,
  input  logic [1:0]            edge_type,
  input  logic [WIDTH_BITS-1:0] pulse_width,
  input  logic [COUNT_BITS-1:0] pulse_count,
  input  logic [WIDTH_BITS-1:0] pulse_gap,
  output logic                  trig_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  pgen_state_t           state_q, state_d;
  logic                  trig_q, trig_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [1:0]            mode_q, mode_d;
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH_BITS-1:0] width_load;

  // Counters hold "cycles remaining minus one", so zero-length requests collapse to one cycle.
  assign width_load = (pulse_width < WIDTH_BITS'(PG_MIN_LEN)) ? '0
                    : pulse_width - WIDTH_BITS'(PG_MIN_LEN);

`ifdef PULSE_TRAIN_EN
  logic [WIDTH_BITS-1:0] width_q, width_d;
  logic [WIDTH_BITS-1:0] gap_q, gap_d;
  logic [COUNT_BITS-1:0] pulses_q, pulses_d;
  logic [WIDTH_BITS-1:0] gap_load;
  logic [COUNT_BITS-1:0] count_load;

  assign gap_load   = (pulse_gap < WIDTH_BITS'(PG_MIN_LEN)) ? '0
                    : pulse_gap - WIDTH_BITS'(PG_MIN_LEN);
  assign count_load = (pulse_count < COUNT_BITS'(PG_MIN_LEN)) ? '0
                    : pulse_count - COUNT_BITS'(PG_MIN_LEN);
`else
  logic unused_train_cfg;
  assign unused_train_cfg = ^{pulse_count, pulse_gap};
`endif

  always_comb begin
    state_d   = state_q;
    trig_d    = trig_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
`ifdef PULSE_TRAIN_EN
    width_d   = width_q;
    gap_d     = gap_q;
    pulses_d  = pulses_q;
`endif

    if (fire && (state_q != PG_IDLE)) overrun_d = 1'b1;

    case (state_q)
      PG_IDLE: begin
        trig_d = idle_level(edge_type, trig_q);
        if (fire) begin
          case (edge_type)
            `EDGE_RISING, `EDGE_FALLING: begin
              state_d = PG_ACTIVE;
              trig_d  = ~idle_level(edge_type, trig_q);
              mode_d  = edge_type;
              cnt_d   = width_load;
`ifdef PULSE_TRAIN_EN
              width_d  = width_load;
              gap_d    = gap_load;
              pulses_d = count_load;
`endif
            end
            `EDGE_BOTH: begin
              trig_d = ~trig_q;
              done_d = 1'b1;
              mode_d = edge_type;
            end
            default: ;
          endcase
        end
      end
      PG_ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
`ifdef PULSE_TRAIN_EN
        end else if (pulses_q != '0) begin
          state_d  = PG_GAP;
          trig_d   = idle_level(mode_q, trig_q);
          cnt_d    = gap_q;
          pulses_d = pulses_q - 1'b1;
`endif
        end else begin
          state_d = PG_IDLE;
          trig_d  = idle_level(mode_q, trig_q);
          done_d  = 1'b1;
        end
      end
`ifdef PULSE_TRAIN_EN
      PG_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = PG_ACTIVE;
          trig_d  = ~idle_level(mode_q, trig_q);
          cnt_d   = width_q;
        end
      end
`endif
      default: state_d = PG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PG_IDLE;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      mode_q    <= `EDGE_NONE;
      cnt_q     <= '0;
`ifdef PULSE_TRAIN_EN
      width_q   <= '0;
      gap_q     <= '0;
      pulses_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
`ifdef PULSE_TRAIN_EN
      width_q   <= width_d;
      gap_q     <= gap_d;
      pulses_q  <= pulses_d;
`endif
    end
  end

  assign trig_out = trig_q;
  assign done     = done_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != PG_IDLE);

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen: waveform-plan reference model feeding an expected queue.
module tb_edge_pulse_gen;

  localparam int WB = 16;
  localparam int CB = 8;
  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_RISE = 2'd1;
  localparam logic [1:0] E_FALL = 2'd2;
  localparam logic [1:0] E_BOTH = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fire = 1'b0;
  logic [1:0]    edge_type = E_NONE;
  logic [WB-1:0] pulse_width = '0;
  logic [CB-1:0] pulse_count = '0;
  logic [WB-1:0] pulse_gap = '0;
  logic          trig_out, busy, done, overrun;

  int total = 0;
  int bad = 0;

  // Expected per-cycle outputs {trig, busy, done, overrun}.
  logic [3:0] exp_q[$];
  // Future pin timeline of the sequence in progress: {trig, busy, done} per cycle.
  logic [2:0] plan_q[$];
  logic       m_level = 1'b0;
  logic       m_over = 1'b0;

  edge_pulse_gen #(.WIDTH_BITS(WB), .COUNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .fire(fire), .edge_type(edge_type),
    .pulse_width(pulse_width), .pulse_count(pulse_count), .pulse_gap(pulse_gap),
    .trig_out(trig_out), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted fire lays out the whole pin waveform for the coming cycles.
  task automatic model_step();
    logic       il;
    int         w, c, g;
    logic [2:0] nxt;
    if (plan_q.size() == 0) begin
      if (fire && (edge_type == E_RISE || edge_type == E_FALL)) begin
        il = (edge_type == E_FALL);
        w  = (pulse_width == 0) ? 1 : int'(pulse_width);
`ifdef PULSE_TRAIN_EN
        c  = (pulse_count == 0) ? 1 : int'(pulse_count);
        g  = (pulse_gap == 0) ? 1 : int'(pulse_gap);
`else
        c  = 1;
        g  = 1;
`endif
        for (int p = 0; p < c; p++) begin
          for (int k = 0; k < w; k++) plan_q.push_back({~il, 1'b1, 1'b0});
          if (p < c - 1)
            for (int k = 0; k < g; k++) plan_q.push_back({il, 1'b1, 1'b0});
        end
        plan_q.push_back({il, 1'b0, 1'b1});
      end else if (fire && edge_type == E_BOTH) begin
        plan_q.push_back({~m_level, 1'b0, 1'b1});
      end else begin
        il = (edge_type == E_FALL) ? 1'b1 : (edge_type == E_BOTH) ? m_level : 1'b0;
        plan_q.push_back({il, 1'b0, 1'b0});
      end
    end else if (fire) begin
      m_over = 1'b1;
    end
    nxt = plan_q.pop_front();
    m_level = nxt[2];
    exp_q.push_back({nxt, m_over});
  endtask

  task automatic step(input logic f, input logic [1:0] et, input int w, input int c, input int g);
    @(negedge clk);
    #1;
    fire        = f;
    edge_type   = et;
    pulse_width = WB'(w);
    pulse_count = CB'(c);
    pulse_gap   = WB'(g);
    model_step();
  endtask

  task automatic idle_steps(input int n, input logic [1:0] et, input int w);
    for (int i = 0; i < n; i++) step(1'b0, et, w, 0, 0);
  endtask

  task automatic check_reset_vals();
    check1("reset_trig", trig_out, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_overrun", overrun, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    fire  = 1'b0;
    edge_type = E_RISE;
    model_step();
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output set.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check1("trig_out", trig_out, e[3]);
        check1("busy", busy, e[2]);
        check1("done", done, e[1]);
        check1("overrun", overrun, e[0]);
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    #20;
    release_reset();

    // Rising, width 4.
    step(1'b1, E_RISE, 4, 0, 0);
    idle_steps(8, E_RISE, 4);
    // Falling, width 0 behaves as one cycle.
    idle_steps(3, E_FALL, 0);
    step(1'b1, E_FALL, 0, 0, 0);
    idle_steps(5, E_FALL, 0);
    // Both: three toggles ten cycles apart.
    idle_steps(2, E_RISE, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, E_BOTH, 7, 2, 2);
      idle_steps(9, E_BOTH, 7);
    end
    // None: fire ignored.
    idle_steps(2, E_NONE, 3);
    step(1'b1, E_NONE, 3, 0, 0);
    idle_steps(5, E_NONE, 3);
    // Rising width 8, overlapping fire at t3, fire on the done cycle at t9.
    step(1'b1, E_RISE, 8, 0, 0);
    idle_steps(2, E_RISE, 8);
    step(1'b1, E_RISE, 2, 0, 0);
    idle_steps(5, E_RISE, 2);
    step(1'b1, E_RISE, 3, 0, 0);
    idle_steps(6, E_RISE, 3);
    // Train request (single pulse unless trains are built in).
    step(1'b1, E_RISE, 2, 3, 3);
    idle_steps(16, E_RISE, 2);

    // Asynchronous reset in the middle of a pulse.
    step(1'b1, E_RISE, 6, 0, 0);
    idle_steps(3, E_RISE, 6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    plan_q.delete();
    exp_q.delete();
    m_level = 1'b0;
    m_over  = 1'b0;
    release_reset();

    // Random traffic with configuration churning every cycle.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
           $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
    idle_steps(40, E_RISE, 1);

    @(negedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
